// File: rtl/countdown_pkg.sv
// ----------------------------------------------------------------------------
// countdown_pkg
// Shared types and constants for the countdown_timer block:
//   - state_e     : timer control states (2-bit encoding)
//   - SEG_TABLE   : 7-segment patterns for hex digits 0..F
//                   (bit7=a .. bit1=g, bit0=dp, active-high)
//   - SEG_BLANK   : all segments off
// ----------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Index 0 is the least significant entry, i.e. SEG_TABLE[4'h3] = 8'hF2.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

endpackage

// File: rtl/seg7_digit.sv
// ----------------------------------------------------------------------------
// seg7_digit
// Purely combinational 4-bit digit to 7-segment pattern decoder.
// Ports:
//   digit   in  [3:0]  digit value 0..F
//   pattern out [7:0]  segment pattern, bit7=a .. bit1=g, bit0=dp, active-high
// ----------------------------------------------------------------------------
module seg7_digit
    import countdown_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] pattern
);

    // Blank is the fallback so an undriven digit shows nothing rather than a
    // misleading numeral.
    always_comb begin
        pattern = SEG_BLANK;
        for (int i = 0; i < 16; i++) begin
            if (digit == 4'(i)) begin
                pattern = SEG_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// ----------------------------------------------------------------------------
// countdown_timer
// Multi-digit countdown timer with per-digit 7-segment outputs.
// Parameters:
//   DIGITS   number of 4-bit digits (1..8)
//   PRESCALE clk cycles per count step (>= 2)
//   BCD      1 = decimal digits 0..9, 0 = hex digits 0..F
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-low
//   load       in   level; loads preset into the count, returns to IDLE
//   start      in   pulse; IDLE -> RUN when count is non-zero
//   pause      in   pulse; toggles RUN <-> PAUSE
//   preset     in   [4*DIGITS-1:0] load value, digit 0 in [3:0]
//   seg        out  [8*DIGITS-1:0] 7-seg patterns, digit 0 in [7:0]
//   running    out  high in RUN
//   done       out  high in DONE
//   done_pulse out  one-cycle pulse when the count reaches zero
// Build option:
//   COUNTDOWN_AUTO_RELOAD_EN  reaching zero reloads the preset captured at
//                             the last load and keeps running (DONE only if
//                             that preset is zero).
// ----------------------------------------------------------------------------
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 32,
    parameter int BCD      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  start,
    input  logic                  pause,
    input  logic [4*DIGITS-1:0]   preset,
    output logic [8*DIGITS-1:0]   seg,
    output logic                  running,
    output logic                  done,
    output logic                  done_pulse
);

    localparam int              CW         = 4 * DIGITS;
    localparam int              PW         = $clog2(PRESCALE);
    localparam logic [3:0]      DIGIT_MAX  = (BCD != 0) ? 4'd9 : 4'hF;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            done_pulse_q, done_pulse_d;

    logic [CW-1:0]   preset_sat;
    logic [CW-1:0]   count_dec;
    logic            borrow;
    logic [3:0]      nib_ld;
    logic [3:0]      nib_dec;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [CW-1:0]   reload_q, reload_d;
`endif

    // Decimal digits cannot hold A..F, so out-of-range preset digits clamp to 9.
    always_comb begin
        preset_sat = preset;
        nib_ld     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib_ld = preset[4*i +: 4];
            if ((BCD != 0) && (nib_ld > 4'd9)) begin
                nib_ld = 4'd9;
            end
            preset_sat[4*i +: 4] = nib_ld;
        end
    end

    // Ripple-borrow decrement: a zero digit wraps to the radix maximum and
    // passes the borrow upward. Only used while count is non-zero.
    always_comb begin
        count_dec = count_q;
        borrow    = 1'b1;
        nib_dec   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nib_dec = count_q[4*i +: 4];
            if (borrow) begin
                if (nib_dec == 4'd0) begin
                    nib_dec = DIGIT_MAX;
                end else begin
                    nib_dec = nib_dec - 4'd1;
                    borrow  = 1'b0;
                end
            end
            count_dec[4*i +: 4] = nib_dec;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        presc_d      = presc_q;
        done_pulse_d = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d     = reload_q;
`endif
        if (load) begin
            state_d = S_IDLE;
            count_d = preset_sat;
            presc_d = '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_d = preset_sat;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && (count_q != '0)) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN: begin
                    // A pause in the tick cycle wins: the prescaler freezes
                    // at its last value and no decrement happens.
                    if (pause) begin
                        state_d = S_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        count_d = count_dec;
                        if (count_dec == '0) begin
                            done_pulse_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (reload_q != '0) begin
                                count_d = reload_q;
                            end else begin
                                state_d = S_DONE;
                            end
`else
                            state_d = S_DONE;
`endif
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (pause) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            presc_q      <= '0;
            done_pulse_q <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            presc_q      <= presc_d;
            done_pulse_q <= done_pulse_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q     <= reload_d;
`endif
        end
    end

    assign running    = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign done_pulse = done_pulse_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_digit u_digit (
            .digit   (count_q[4*g +: 4]),
            .pattern (seg[8*g +: 8])
        );
    end

endmodule

// File: tb/tb_countdown_timer.sv
// ----------------------------------------------------------------------------
// tb_countdown_timer
// Drives a decimal (BCD=1) and a hex (BCD=0) countdown_timer from the same
// inputs and compares both against an integer-valued model of the timer.
// ----------------------------------------------------------------------------
module tb_countdown_timer;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [7:0]  preset = 8'h00;

    logic [15:0] seg_b, seg_h;
    logic        run_b, run_h, done_b, done_h, dp_b, dp_h;

    int passed = 0;
    int total  = 0;

    countdown_timer #(.DIGITS(2), .PRESCALE(P), .BCD(1)) u_bcd (
        .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause),
        .preset(preset), .seg(seg_b), .running(run_b), .done(done_b),
        .done_pulse(dp_b)
    );

    countdown_timer #(.DIGITS(2), .PRESCALE(P), .BCD(0)) u_hex (
        .clk(clk), .rst(rst), .load(load), .start(start), .pause(pause),
        .preset(preset), .seg(seg_h), .running(run_h), .done(done_h),
        .done_pulse(dp_h)
    );

    always #5 clk = ~clk;

    // Model: count kept as a plain integer value; mode 0=idle 1=run 2=pause 3=done.
    int m_mode [2];
    int m_n    [2];
    int m_ph   [2];
    int m_latch[2];
    bit m_pulse[2];
    bit m_valid = 1'b0;

    function automatic logic [7:0] pat(int d);
        case (d)
            0: return 8'hFC;  1: return 8'h60;  2: return 8'hDA;  3: return 8'hF2;
            4: return 8'h66;  5: return 8'hB6;  6: return 8'hBE;  7: return 8'hE0;
            8: return 8'hFE;  9: return 8'hF6;  10: return 8'hEE; 11: return 8'h3E;
            12: return 8'h9C; 13: return 8'h7A; 14: return 8'h9E; 15: return 8'h8E;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] exp_seg(int n, bit bcd);
        logic [15:0] r;
        int d0, d1;
        d0 = bcd ? (n % 10) : (n % 16);
        d1 = bcd ? ((n / 10) % 10) : ((n / 16) % 16);
        r[7:0]  = pat(d0);
        r[15:8] = pat(d1);
        return r;
    endfunction

    function automatic int to_val(logic [7:0] p, bit bcd);
        int hi, lo;
        hi = int'(p[7:4]);
        lo = int'(p[3:0]);
        if (bcd) begin
            if (hi > 9) hi = 9;
            if (lo > 9) lo = 9;
            return hi * 10 + lo;
        end
        return hi * 16 + lo;
    endfunction

    task automatic step(int k);
        bit bcd = (k == 0);
        m_pulse[k] = 1'b0;
        if (!rst) begin
            m_mode[k] = 0; m_n[k] = 0; m_ph[k] = 0; m_latch[k] = 0;
        end else if (load) begin
            m_n[k] = to_val(preset, bcd);
            m_latch[k] = m_n[k];
            m_ph[k] = 0;
            m_mode[k] = 0;
        end else begin
            case (m_mode[k])
                0: if (start && m_n[k] != 0) begin m_mode[k] = 1; m_ph[k] = 0; end
                1: begin
                    if (pause) m_mode[k] = 2;
                    else if (m_ph[k] == P - 1) begin
                        m_ph[k] = 0;
                        m_n[k] = m_n[k] - 1;
                        if (m_n[k] == 0) begin
                            m_pulse[k] = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (m_latch[k] != 0) m_n[k] = m_latch[k];
                            else m_mode[k] = 3;
`else
                            m_mode[k] = 3;
`endif
                        end
                    end else m_ph[k] = m_ph[k] + 1;
                end
                2: if (pause) m_mode[k] = 1;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) step(k);
        m_valid = 1'b1;
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("bcd_seg",  32'(seg_b),  32'(exp_seg(m_n[0], 1'b1)));
            check("bcd_run",  32'(run_b),  32'(m_mode[0] == 1));
            check("bcd_done", 32'(done_b), 32'(m_mode[0] == 3));
            check("bcd_dp",   32'(dp_b),   32'(m_pulse[0]));
            check("hex_seg",  32'(seg_h),  32'(exp_seg(m_n[1], 1'b0)));
            check("hex_run",  32'(run_h),  32'(m_mode[1] == 1));
            check("hex_done", 32'(done_h), 32'(m_mode[1] == 3));
            check("hex_dp",   32'(dp_h),   32'(m_pulse[1]));
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(logic [7:0] v);
        preset = v; load = 1'b1; cyc(1); load = 1'b0;
    endtask

    task automatic do_start;
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic do_pause;
        pause = 1'b1; cyc(1); pause = 1'b0;
    endtask

    initial begin
        cyc(3);
        check("lit_rst_seg", 32'(seg_b), 32'h0000FCFC);
        check("lit_rst_done", 32'(done_b), 32'd0);
        rst = 1'b1;

        do_load(8'h12);
        check("lit_load12_seg", 32'(seg_b), 32'h000060DA);
        check("lit_load12_run", 32'(run_b), 32'd0);

        // 10 (BCD) and 0x10 (hex): first tick 4 cycles after the start edge.
        do_load(8'h10);
        do_start;
        cyc(4);
        check("lit_bcd_borrow", 32'(seg_b), 32'h0000FCF6);
        check("lit_hex_borrow", 32'(seg_h), 32'h0000FC8E);
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // Tenth tick lands 40 cycles after the start edge.
        cyc(35);
        check("lit_done_early", 32'(done_b), 32'd0);
        cyc(1);
        check("lit_done_set", 32'(done_b), 32'd1);
        check("lit_done_pulse", 32'(dp_b), 32'd1);
        cyc(1);
        check("lit_pulse_clear", 32'(dp_b), 32'd0);
        do_start;
        cyc(2);
        check("lit_start_in_done", 32'(done_b), 32'd1);
`else
        cyc(36);
        check("lit_reload_pulse", 32'(dp_b), 32'd1);
        check("lit_reload_run", 32'(run_b), 32'd1);
        check("lit_reload_done", 32'(done_b), 32'd0);
`endif

        do_load(8'h1C);
        check("lit_bcd_clamp", 32'(seg_b), 32'h000060F6);
        check("lit_hex_1c", 32'(seg_h), 32'h0000609C);

        // Pause at prescaler 1, hold, then resume: 3 more cycles to a tick.
        do_load(8'h05);
        do_start;
        cyc(1);
        do_pause;
        cyc(20);
        check("lit_pause_hold", 32'(seg_b), 32'h0000FCB6);
        check("lit_pause_run", 32'(run_b), 32'd0);
        do_pause;
        cyc(3);
        check("lit_resume_tick", 32'(seg_b), 32'h0000FC66);

        do_load(8'h00);
        do_start;
        cyc(1);
        check("lit_start_zero", 32'(run_b), 32'd0);

        do_load(8'h50);
        do_start;
        cyc(6);
        do_load(8'h37);
        check("lit_load_in_run", 32'(seg_b), 32'h0000F2E0);
        check("lit_load_idle", 32'(run_b), 32'd0);

        do_start;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        check("lit_midrun_rst_seg", 32'(seg_b), 32'h0000FCFC);
        check("lit_midrun_rst_dp", 32'(dp_b), 32'd0);
        check("lit_midrun_rst_run", 32'(run_b), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom % 500) != 0;
            load  = ($urandom % 150) == 0;
            preset = (($urandom % 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 18));
            start = ($urandom % 8) == 0;
            pause = ($urandom % 20) == 0;
            cyc(1);
        end
        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
